mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 single-bit mux datapath between 8 requesters.
- Each requester i presents a request req[i] and a data bit din[i].
- The block grants one requester at a time, drives the mux select, and forwards the selected bit with a valid flag.
- Sits in front of the team's gate-level 8:1 mux cell (mux8x1) and sequences its select lines.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one grant is held; legal range 1..16.
- CNT_W, 4, width of the hold counter; must satisfy 2**CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- req  input  8  request per requester, level-sensitive.
- din  input  8  data bit per requester.
- lock  input  1  holds the current grant past MAX_HOLD (MUX_ARB_LOCK_EN only; ignored otherwise).
- gnt  output  8  one-hot grant, registered.
- sel  output  3  mux select = index of granted requester, registered.
- valid  output  1  high while a grant is active, registered.
- dout  output  1  din[sel] when valid, else 0; combinational from registered sel.

Behaviour:
- Reset:
  - Interface as decided: one clock; reset is synchronous and active-low (clk, rst_n).
  - While rst_n=0 at a clk edge: gnt=0, sel=0, valid=0, ptr=0, cnt=0, state=IDLE.
  - Reset mid-grant aborts the grant; outputs are zero from the next cycle.
- State IDLE:
  - valid=0, gnt=0, sel holds its last value, dout=0.
  - If req!=0 at an edge: choose the first set bit scanning upward from ptr, wrapping 7->0.
  - Load gnt/sel, set valid=1, cnt=0, go to GRANT.
  - Latency from req high in IDLE to grant is 1 cycle.
- State GRANT:
  - Each edge, release if req[sel]==0 or cnt==MAX_HOLD-1; otherwise cnt++.
  - On release, ptr = sel+1 mod 8 (7 wraps to 0).
  - Same edge: re-arbitrate over req from the new ptr, ignoring the released requester's bit only when it is 0.
  - If a winner exists: back-to-back grant with no idle bubble; load the new gnt/sel, cnt=0, stay in GRANT.
  - If no winner: gnt=0, valid=0, go to IDLE.
- Fairness:
  - A sole requester that stays high is re-granted immediately with cnt restarted. valid stays 1, sel is unchanged.
  - With N requesters active, each waits at most (N-1)*MAX_HOLD cycles.
- MAX_HOLD=1: every grant lasts exactly one cycle, rotating each cycle.
- Invariants: gnt is always one-hot or zero; gnt==(1<<sel) whenever valid=1.
- Late requests: a request arriving during another's grant is considered only at the next release edge.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - While valid=1 and lock=1, the MAX_HOLD expiry is suppressed and cnt saturates at MAX_HOLD-1.
  - A release caused by req[sel]==0 still occurs.
  - lock has no effect in IDLE.
- Undefined: the lock port exists but is ignored; behaviour is pure round-robin with MAX_HOLD expiry.

Decomposition:
- Shared package mux_arb_pkg:
  - state encoding (IDLE=0, GRANT=1);
  - NREQ=8, SEL_W=3;
  - MAX_HOLD default.
- Sub-module rr_pick8: combinational.
  - Inputs: 8-bit req and 3-bit ptr.
  - Outputs: found flag and 3-bit winner index (rotate, priority-encode, un-rotate).
- The data path instantiates the existing mux8x1 with din and sel; output gated by valid.

Test Plan:
- Reset and first grant: hold rst_n=0 for 3 cycles with req=8'hFF -> gnt=0, valid=0 throughout; release -> one cycle later gnt=8'h01, sel=0, valid=1.
- Two requesters: req=8'h22 constant, MAX_HOLD=4 -> gnt=8'h02 for 4 cycles, then 8'h20 for 4, then 8'h02, with no valid gap.
- Sole requester: req=8'h80 constant -> sel=7 and valid=1 continuously; cnt restarts every 4 cycles; ptr wraps to 0.
- Early drop: from IDLE, req=8'h04 for 2 cycles then 0 -> gnt=8'h04 for 2 cycles, then gnt=0, valid=0 one cycle after the drop.
- Data forwarding: req=8'h10, din=8'hEF -> sel=4, dout=0; din=8'h10 -> dout=1; after req drops -> dout=0.
- Lock and mid-grant reset (MUX_ARB_LOCK_EN): req=8'h03, lock=1 during grant 0 -> gnt=8'h01 past 4 cycles; lock=0 -> gnt=8'h02 next cycle; rst_n=0 mid-grant -> all outputs 0 the next cycle; first grant after reset is requester 0.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants for the round-robin mux arbiter: requester count, select width,
// default hold limit and FSM state encoding.
package mux_arb_pkg;
    localparam int NREQ         = 8;
    localparam int SEL_W        = 3;
    localparam int MAX_HOLD_DEF = 4;
    localparam int CNT_W_DEF    = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = NREQ'(1) << idx;
    endfunction
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-side bundle of the arbiter: requests, data bits, lock, and the
// registered grant/select/valid plus forwarded data bit.
interface mux_rr_arbiter_if;
    import mux_arb_pkg::*;

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  din;
    logic             lock;
    logic [NREQ-1:0]  gnt;
    logic [SEL_W-1:0] sel;
    logic             valid;
    logic             dout;

    modport master (output req, din, lock, input gnt, sel, valid, dout);
    modport slave  (input req, din, lock, output gnt, sel, valid, dout);
endinterface

// File: rtl/mux8x1.sv
// Single-bit 8:1 mux cell driven by the arbiter's select lines.
module mux8x1 (
    input  logic [7:0] d,
    input  logic [2:0] s,
    output logic       y
);
    logic [3:0] lvl1;
    logic [1:0] lvl2;

    assign lvl1[0] = s[0] ? d[1] : d[0];
    assign lvl1[1] = s[0] ? d[3] : d[2];
    assign lvl1[2] = s[0] ? d[5] : d[4];
    assign lvl1[3] = s[0] ? d[7] : d[6];
    assign lvl2[0] = s[1] ? lvl1[1] : lvl1[0];
    assign lvl2[1] = s[1] ? lvl1[3] : lvl1[2];
    assign y       = s[2] ? lvl2[1] : lvl2[0];
endmodule

// File: rtl/mux_rr_arbiter_rr_pick8.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] winner
);
    logic [NREQ-1:0]  rot;
    logic [SEL_W-1:0] offs;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        rot   = NREQ'({req, req} >> ptr);
        offs  = '0;
        found = |rot;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) offs = SEL_W'(i);
        end
        winner = ptr + offs;
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 single-bit mux between 8 requesters.
// Optional macro MUX_ARB_LOCK_EN: lock suppresses the MAX_HOLD expiry of a grant.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_rr_arbiter_if.slave   bus
);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [NREQ-1:0]  gnt_q,   gnt_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic             valid_q, valid_d;

    logic             hold_last;
    logic             expire;
    logic             rel_now;
    logic [SEL_W-1:0] pick_ptr;
    logic             pick_found;
    logic [SEL_W-1:0] pick_win;
    logic             mux_y;

    assign hold_last = (cnt_q == HOLD_LAST);

`ifdef MUX_ARB_LOCK_EN
    assign expire = hold_last && !bus.lock;
`else
    logic unused_lock;
    assign unused_lock = bus.lock;
    assign expire      = hold_last;
`endif

    assign rel_now  = (state_q == ST_GRANT) && (!bus.req[sel_q] || expire);
    // In GRANT the picker only matters on a release edge, where the new ptr is sel+1.
    assign pick_ptr = (state_q == ST_GRANT) ? sel_q + SEL_W'(1) : ptr_q;

    rr_pick8 u_pick (
        .req    (bus.req),
        .ptr    (pick_ptr),
        .found  (pick_found),
        .winner (pick_win)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;

        case (state_q)
            ST_IDLE: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                if (pick_found) begin
                    gnt_d   = onehot(pick_win);
                    sel_d   = pick_win;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rel_now) begin
                    ptr_d = sel_q + SEL_W'(1);
                    if (pick_found) begin
                        gnt_d   = onehot(pick_win);
                        sel_d   = pick_win;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (!hold_last) begin
                    // A locked grant sits at HOLD_LAST until lock drops.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    mux8x1 u_mux (
        .d (bus.din),
        .s (sel_q),
        .y (mux_y)
    );

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.valid = valid_q;
    assign bus.dout  = valid_q & mux_y;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: vector table, corner-case sequences,
// and randomized traffic against a requester-level reference model.
module tb_mux_rr_arbiter;
    import mux_arb_pkg::*;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 4;
`ifdef MUX_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_rr_arbiter_if bus_if ();

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the mux, for how many cycles, and where the scan starts.
    int m_owner    = -1;
    int m_held     = 0;
    int m_ptr      = 0;
    int m_last_sel = 0;

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic [7:0] din;
        logic       lock;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       dout;
    } vec_t;

    vec_t vecs[$];

    function automatic int find_first(input logic [7:0] r, input int from);
        for (int i = 0; i < 8; i++) begin
            if (r[(from + i) % 8]) return (from + i) % 8;
        end
        return -1;
    endfunction

    task automatic modelStep();
        int  w;
        bit  keep;
        if (!rst_n) begin
            m_owner    = -1;
            m_held     = 0;
            m_ptr      = 0;
            m_last_sel = 0;
        end else if (m_owner < 0) begin
            w = find_first(bus_if.req, m_ptr);
            if (w >= 0) begin
                m_owner    = w;
                m_held     = 1;
                m_last_sel = w;
            end
        end else begin
            keep = bus_if.req[m_owner] &&
                   ((m_held < MAX_HOLD) || (LOCK_EN && bus_if.lock));
            if (keep) begin
                m_held = m_held + 1;
            end else begin
                m_ptr = (m_owner + 1) % 8;
                w     = find_first(bus_if.req, m_ptr);
                if (w >= 0) begin
                    m_owner    = w;
                    m_held     = 1;
                    m_last_sel = w;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic [7:0] r, input logic [7:0] d,
                                 input logic l);
        rst_n       = rn;
        bus_if.req  = r;
        bus_if.din  = d;
        bus_if.lock = l;
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] eg, input logic [2:0] es,
                               input logic ev, input logic ed);
        checks++;
        if (bus_if.gnt !== eg || bus_if.sel !== es || bus_if.valid !== ev || bus_if.dout !== ed) begin
            errors++;
            $display("[TB] FAIL %s: got gnt=%h sel=%0d valid=%b dout=%b, expected gnt=%h sel=%0d valid=%b dout=%b",
                     name, bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.dout, eg, es, ev, ed);
        end
    endtask

    task automatic checkModel(input string name);
        logic       ev;
        logic [2:0] es;
        logic [7:0] eg;
        logic       ed;
        ev = (m_owner >= 0);
        es = 3'(m_last_sel);
        eg = ev ? (8'd1 << es) : 8'd0;
        ed = ev ? bus_if.din[es] : 1'b0;
        checkOutput(name, eg, es, ev, ed);
    endtask

    task automatic addVec(input logic rn, input logic [7:0] r, input logic [7:0] d, input logic l,
                          input logic [7:0] g, input logic [2:0] s, input logic v, input logic dd,
                          input int n);
        for (int k = 0; k < n; k++) vecs.push_back('{rn, r, d, l, g, s, v, dd});
    endtask

    initial begin
        bus_if.req  = '0;
        bus_if.din  = '0;
        bus_if.lock = 1'b0;

        addVec(1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3);
        addVec(1'b1, 8'hFF, 8'h00, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, 4);
        addVec(1'b1, 8'hFF, 8'h00, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, 1);
        addVec(1'b0, 8'h22, 8'h20, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1);
        addVec(1'b1, 8'h22, 8'h20, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, 4);
        addVec(1'b1, 8'h22, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b1, 4);
        addVec(1'b1, 8'h22, 8'h20, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, 1);
        addVec(1'b0, 8'h80, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1);
        addVec(1'b1, 8'h80, 8'hFF, 1'b0, 8'h80, 3'd7, 1'b1, 1'b1, 9);
        addVec(1'b1, 8'h81, 8'hFF, 1'b0, 8'h80, 3'd7, 1'b1, 1'b1, 3);
        addVec(1'b1, 8'h81, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b1, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].req, vecs[i].din, vecs[i].lock);
            checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].valid, vecs[i].dout);
        end

        // Early drop: released one cycle after req falls, sel keeps its last value.
        applyStimulus(1'b0, 8'h00, 8'hFF, 1'b0);
        checkOutput("drop_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h04, 8'hFF, 1'b0);
        checkOutput("drop_g1", 8'h04, 3'd2, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h04, 8'hFF, 1'b0);
        checkOutput("drop_g2", 8'h04, 3'd2, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h00, 8'hFF, 1'b0);
        checkOutput("drop_idle", 8'h00, 3'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h00, 8'hFF, 1'b0);
        checkOutput("drop_idle2", 8'h00, 3'd2, 1'b0, 1'b0);

        // Data forwarding follows din combinationally and is gated by valid.
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h10, 8'hEF, 1'b0);
        checkOutput("fwd_zero", 8'h10, 3'd4, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h10, 8'h10, 1'b0);
        checkOutput("fwd_one", 8'h10, 3'd4, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h00, 8'h10, 1'b0);
        checkOutput("fwd_drop", 8'h00, 3'd4, 1'b0, 1'b0);

        // Reset in the middle of a grant.
        applyStimulus(1'b0, 8'h00, 8'hFF, 1'b0);
        applyStimulus(1'b1, 8'h03, 8'hFF, 1'b0);
        applyStimulus(1'b1, 8'h03, 8'hFF, 1'b0);
        applyStimulus(1'b1, 8'h06, 8'hFF, 1'b0);
        checkOutput("midrst_pre", 8'h02, 3'd1, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h06, 8'hFF, 1'b0);
        checkOutput("midrst_zero", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h03, 8'hFF, 1'b0);
        checkOutput("midrst_first", 8'h01, 3'd0, 1'b1, 1'b1);

        applyStimulus(1'b0, 8'h00, 8'hFF, 1'b0);
        if (LOCK_EN) begin
            for (int k = 0; k < 7; k++) begin
                applyStimulus(1'b1, 8'h03, 8'hFF, 1'b1);
                checkOutput($sformatf("lock_hold%0d", k), 8'h01, 3'd0, 1'b1, 1'b1);
            end
            applyStimulus(1'b1, 8'h03, 8'hFF, 1'b0);
            checkOutput("lock_release", 8'h02, 3'd1, 1'b1, 1'b1);
            applyStimulus(1'b1, 8'h01, 8'hFF, 1'b1);
            checkOutput("lock_drop", 8'h01, 3'd0, 1'b1, 1'b1);
        end else begin
            for (int k = 0; k < MAX_HOLD; k++) begin
                applyStimulus(1'b1, 8'h03, 8'hFF, 1'b1);
                checkOutput($sformatf("nolock_hold%0d", k), 8'h01, 3'd0, 1'b1, 1'b1);
            end
            applyStimulus(1'b1, 8'h03, 8'hFF, 1'b1);
            checkOutput("nolock_expire", 8'h02, 3'd1, 1'b1, 1'b1);
        end

        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 500; k++) begin
            logic       rn;
            logic [7:0] r;
            rn = ($urandom_range(0, 49) != 0);
            r  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom & $urandom);
            applyStimulus(rn, r, 8'($urandom), ($urandom_range(0, 3) == 0));
            checkModel($sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
